// File: rtl/lfsr_wb_sequencer.sv
// Wishbone master for the LFSR slave: holds it in reset, writes four seed bytes, loads, runs,
// then reads 8*count output bits and assembles them MSB-first into a byte stream.
module lfsr_wb_sequencer #(
   parameter logic [2:0] READ_ADDR      = 3'b100,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_seed,
   input  logic [7:0]  i_count,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [2:0]  o_wb_addr,
   output logic [7:0]  o_wb_data,
   input  logic        i_wb_stall,
   input  logic        i_wb_data,
   input  logic        i_wb_ack
);
   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    CTRL_ADDR = 3'd4;
   localparam logic [2:0]    LAST_STEP = 3'd6;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_GAP, S_DONE} state_t;

   state_t        r_state;
   logic [31:0]   r_seed;
   logic [7:0]    r_count;
   logic [7:0]    r_byte_cnt;
   logic [2:0]    r_step;
   logic [2:0]    r_bit_cnt;
   logic          r_rd;
   logic [6:0]    r_sr;
   logic [TW-1:0] r_tmo;

   logic          w_accept;
   logic          w_ack;
   logic          w_tmo;
   logic [2:0]    w_next_step;

   // Acks are only honoured once the request has been accepted (not while stalled).
   assign w_accept    = (r_state == S_REQ) && !i_wb_stall;
   assign w_ack       = i_wb_ack && (w_accept || (r_state == S_WAIT_ACK));
   assign w_tmo       = ((r_state == S_REQ) || (r_state == S_WAIT_ACK)) && (r_tmo == TMO_LAST);
   assign w_next_step = r_step + 3'd1;

   function automatic logic [2:0] f_addr(input logic [2:0] step);
      if ((step >= 3'd1) && (step <= 3'd4)) f_addr = step - 3'd1;
      else                                  f_addr = CTRL_ADDR;
   endfunction

   function automatic logic [7:0] f_data(input logic [2:0] step, input logic [31:0] seed);
      case (step)
         3'd0:    f_data = 8'h01;
         3'd1:    f_data = seed[7:0];
         3'd2:    f_data = seed[15:8];
         3'd3:    f_data = seed[23:16];
         3'd4:    f_data = seed[31:24];
         3'd5:    f_data = 8'h02;
         default: f_data = 8'h00;
      endcase
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_seed       <= '0;
         r_count      <= '0;
         r_byte_cnt   <= '0;
         r_step       <= '0;
         r_bit_cnt    <= '0;
         r_rd         <= 1'b0;
         r_sr         <= '0;
         r_tmo        <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= '0;
         o_wb_data    <= '0;
      end else begin
         o_done       <= 1'b0;
         o_byte_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_seed     <= i_seed;
                  r_count    <= i_count;
                  r_step     <= '0;
                  r_rd       <= 1'b0;
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_sr       <= '0;
                  r_tmo      <= '0;
                  o_err      <= 1'b0;
                  o_busy     <= 1'b1;
                  o_wb_cyc   <= 1'b1;
                  o_wb_stb   <= 1'b1;
                  o_wb_we    <= 1'b1;
                  o_wb_addr  <= CTRL_ADDR;
                  o_wb_data  <= 8'h01;
                  r_state    <= S_REQ;
               end
            end
            S_REQ, S_WAIT_ACK: begin
               r_tmo <= r_tmo + TW'(1);
               if (w_ack) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  r_state  <= S_GAP;
                  if (r_rd) begin
                     r_sr      <= {r_sr[5:0], i_wb_data};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        o_byte       <= {r_sr, i_wb_data};
                        o_byte_valid <= 1'b1;
                        r_byte_cnt   <= r_byte_cnt + 8'd1;
                     end
                  end
               end else if (w_tmo) begin
                  // Abort: any partially assembled byte is thrown away.
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  o_wb_we   <= 1'b0;
                  o_wb_addr <= '0;
                  o_wb_data <= '0;
                  o_err     <= 1'b1;
                  o_done    <= 1'b1;
                  o_busy    <= 1'b0;
                  r_sr      <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= S_DONE;
               end else if (w_accept) begin
                  o_wb_stb <= 1'b0;
                  r_state  <= S_WAIT_ACK;
               end
            end
            S_GAP: begin
               r_tmo <= '0;
               if (!r_rd && (r_step != LAST_STEP)) begin
                  r_step    <= w_next_step;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b1;
                  o_wb_addr <= f_addr(w_next_step);
                  o_wb_data <= f_data(w_next_step, r_seed);
                  r_state   <= S_REQ;
               end else if ((r_rd && (r_byte_cnt == r_count)) || (!r_rd && (r_count == 8'd0))) begin
                  o_done    <= 1'b1;
                  o_busy    <= 1'b0;
                  o_wb_we   <= 1'b0;
                  o_wb_addr <= '0;
                  o_wb_data <= '0;
                  r_state   <= S_DONE;
               end else begin
                  r_rd      <= 1'b1;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b0;
                  o_wb_addr <= READ_ADDR;
                  o_wb_data <= '0;
                  r_state   <= S_REQ;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lfsr_wb_sequencer.sv
// Scoreboard bench: stimulus queues expected bus requests and bytes; a slave/monitor process
// answers the bus and checks everything the DUT presents against those queues.
module tb_lfsr_wb_sequencer;
   logic        i_clk = 1'b0;
   logic        i_reset, i_start;
   logic [31:0] i_seed;
   logic [7:0]  i_count;
   logic        o_busy, o_done, o_err, o_byte_valid;
   logic [7:0]  o_byte;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [2:0]  o_wb_addr;
   logic [7:0]  o_wb_data;
   logic        i_wb_stall = 1'b0, i_wb_data = 1'b0, i_wb_ack = 1'b0;

   lfsr_wb_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_seed(i_seed), .i_count(i_count),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [11:0] exp_req[$];   // {we, addr, data}
   logic [7:0]  exp_byte[$];
   bit          bits_q[$];    // bits the slave returns on reads, in order

   int txn = 0, bytes_seen = 0, last_cyc_run = 0, stall_pres = 0;
   int stall_at = -1, noack_at = -1;
   bit rnd = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic ack_now(input bit rd);
      i_wb_ack = 1'b1;
      if (rd) i_wb_data = (bits_q.size() != 0) ? bits_q.pop_front() : 1'b0;
   endtask

   // Slave + monitor
   initial begin : slave_mon
      int stall_left, pend_lat, pres, cyc_run, lat;
      bit in_req, pend, pend_rd;
      logic [11:0] got, first_req;
      stall_left = 0; pend_lat = 0; pres = 0; cyc_run = 0; lat = 0;
      in_req = 0; pend = 0; pend_rd = 0; first_req = '0;
      forever begin
         @(negedge i_clk);
         if (o_byte_valid) begin
            bytes_seen++;
            if (exp_byte.size() == 0) chk("byte_unexpected", {24'd0, o_byte}, 32'h100);
            else                      chk("byte_value", {24'd0, o_byte}, {24'd0, exp_byte.pop_front()});
         end
         if (o_wb_cyc) cyc_run++;
         else if (cyc_run != 0) begin last_cyc_run = cyc_run; cyc_run = 0; end
         i_wb_ack   = 1'b0;
         i_wb_stall = 1'b0;
         i_wb_data  = 1'($urandom);
         if (i_reset) begin
            in_req = 0; pend = 0;
         end else if (pend) begin
            if (pend_lat == 0) begin ack_now(pend_rd); pend = 0; end
            else pend_lat--;
         end else if (o_wb_cyc && o_wb_stb) begin
            got = {o_wb_we, o_wb_addr, o_wb_data};
            if (!in_req) begin
               in_req = 1; pres = 0; first_req = got;
               stall_left = (txn == stall_at) ? 3 : (rnd ? int'($urandom_range(0, 2)) : 0);
            end
            pres++;
            if (stall_left > 0) begin
               stall_left--;
               i_wb_stall = 1'b1;
               if (rnd) i_wb_ack = 1'($urandom);
            end else begin
               in_req = 0;
               chk("req_stable", {20'd0, got}, {20'd0, first_req});
               if (exp_req.size() == 0) chk("req_unexpected", {20'd0, got}, 32'h1000);
               else                     chk("req", {20'd0, got}, {20'd0, exp_req.pop_front()});
               if (txn == stall_at) stall_pres = pres;
               if (txn != noack_at) begin
                  lat = rnd ? int'($urandom_range(0, 2)) : 1;
                  if (lat == 0) ack_now(!o_wb_we);
                  else begin pend = 1; pend_lat = lat - 1; pend_rd = !o_wb_we; end
               end
               txn++;
            end
         end else if (!o_wb_cyc && rnd) begin
            i_wb_ack = 1'($urandom);
         end
      end
   end

   task automatic push_exp(input logic [31:0] seed, input int count);
      logic [7:0] v;
      exp_req.push_back({1'b1, 3'd4, 8'h01});
      for (int i = 0; i < 4; i++) exp_req.push_back({1'b1, 3'(i), 8'((seed >> (8 * i)) & 32'hFF)});
      exp_req.push_back({1'b1, 3'd4, 8'h02});
      exp_req.push_back({1'b1, 3'd4, 8'h00});
      for (int i = 0; i < 8 * count; i++) exp_req.push_back({1'b0, 3'd4, 8'h00});
      while (bits_q.size() < 8 * count) bits_q.push_back(1'($urandom));
      for (int j = 0; j < count; j++) begin
         v = 0;
         for (int i = 0; i < 8; i++) v = 8'(v * 2 + int'(bits_q[8 * j + i]));
         exp_byte.push_back(v);
      end
   endtask

   task automatic pulse_start(input logic [31:0] seed, input int count);
      @(negedge i_clk);
      i_start = 1'b1; i_seed = seed; i_count = 8'(count);
      @(negedge i_clk);
      i_start = 1'b0; i_seed = $urandom; i_count = 8'($urandom);
      chk("busy_after_start", {31'd0, o_busy}, 32'd1);
      chk("err_after_start", {31'd0, o_err}, 32'd0);
   endtask

   // Cycle 1 is the cycle right after the start edge; dc returns the o_done cycle.
   task automatic run(input logic [31:0] seed, input int count, input int mid, input bit dstart,
                      output int dc);
      int c;
      push_exp(seed, count);
      pulse_start(seed, count);
      c = 1;
      while (!o_done && c < 20000) begin
         i_start = (c == mid);
         @(negedge i_clk);
         c++;
      end
      i_start = 1'b0;
      if (!o_done) chk("done_timeout", 32'd0, 32'd1);
      else         chk("busy_at_done", {31'd0, o_busy}, 32'd0);
      i_start = dstart;
      @(negedge i_clk);
      i_start = 1'b0;
      chk("done_single_pulse", {31'd0, o_done}, 32'd0);
      dc = c;
   endtask

   task automatic flush();
      exp_req.delete(); exp_byte.delete(); bits_q.delete();
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int dc, base, b0, c;
      bit done_seen;
      logic [7:0] bytes_fixed[2];
      i_reset = 1'b1; i_start = 1'b0; i_seed = '0; i_count = '0;
      repeat (3) @(negedge i_clk);
      chk("reset_outputs", {o_busy, o_done, o_err, o_byte_valid, o_wb_cyc, o_wb_stb, o_wb_we,
                            o_wb_addr, o_wb_data, o_byte}, 32'd0);
      i_reset = 1'b0;

      // Configure-only
      base = txn; b0 = bytes_seen;
      run(32'h6424_0F15, 0, -1, 0, dc);
      chk("cfg_done_cycle", dc, 22);
      chk("cfg_err", {31'd0, o_err}, 32'd0);
      chk("cfg_txns", txn - base, 7);
      chk("cfg_no_bytes", bytes_seen - b0, 0);
      chk("cfg_cyc_run", last_cyc_run, 2);

      // Fixed readback: 0xA5 then 0xF0
      bytes_fixed[0] = 8'hA5; bytes_fixed[1] = 8'hF0;
      for (int j = 0; j < 2; j++)
         for (int i = 7; i >= 0; i--) bits_q.push_back(bytes_fixed[j][i]);
      base = txn; b0 = bytes_seen;
      run(32'h1234_5678, 2, -1, 0, dc);
      chk("rd_done_cycle", dc, 70);
      chk("rd_txns", txn - base, 23);
      chk("rd_bytes", bytes_seen - b0, 2);
      chk("rd_byte_q_empty", exp_byte.size(), 0);

      // Stall on step 2
      base = txn; stall_at = base + 2;
      run(32'hDEAD_0FEF, 0, -1, 0, dc);
      stall_at = -1;
      chk("stall_stb_cycles", stall_pres, 4);
      chk("stall_done_cycle", dc, 25);
      chk("stall_err", {31'd0, o_err}, 32'd0);

      // Timeout on step 3, then recovery
      base = txn; noack_at = base + 3;
      run(32'hCAFE_BABE, 0, -1, 0, dc);
      noack_at = -1;
      chk("tmo_cyc_cycles", last_cyc_run, 16);
      chk("tmo_err", {31'd0, o_err}, 32'd1);
      chk("tmo_done_cycle", dc, 26);
      chk("tmo_remaining_reqs", exp_req.size(), 3);
      flush();
      run(32'h0BAD_F00D, 1, -1, 0, dc);
      chk("recover_err", {31'd0, o_err}, 32'd0);
      chk("recover_done_cycle", dc, 46);

      // Start mid-sequence and in the done cycle is ignored
      base = txn;
      run(32'h5A5A_A5A5, 1, 10, 1, dc);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("ignored_start_idle", {31'd0, o_busy | o_wb_cyc}, 32'd0);
      end
      chk("ignored_start_txns", txn - base, 15);
      chk("ignored_start_done_cycle", dc, 46);

      // Reset during read 5
      base = txn; b0 = bytes_seen;
      push_exp(32'h1357_9BDF, 1);
      pulse_start(32'h1357_9BDF, 1);
      c = 0;
      while (!(o_wb_stb && txn == base + 12) && c < 500) begin @(negedge i_clk); c++; end
      chk("reach_read5", {31'd0, o_wb_stb}, 32'd1);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("midreset_outputs", {o_busy, o_done, o_err, o_byte_valid, o_wb_cyc, o_wb_stb, o_wb_we,
                               o_wb_addr, o_wb_data, o_byte}, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;
      flush();
      done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         done_seen |= o_done;
      end
      chk("midreset_no_done", {31'd0, done_seen}, 32'd0);
      chk("midreset_no_byte", bytes_seen - b0, 0);
      base = txn;
      run(32'h2468_ACE0, 1, -1, 0, dc);
      chk("after_reset_txns", txn - base, 15);
      chk("after_reset_done_cycle", dc, 46);

      // Maximum count
      base = txn; b0 = bytes_seen;
      run($urandom, 255, -1, 0, dc);
      chk("max_done_cycle", dc, 6142);
      chk("max_txns", txn - base, 2047);
      chk("max_bytes", bytes_seen - b0, 255);

      // Randomised slave timing and spurious acks
      rnd = 1'b1;
      for (int r = 0; r < 6; r++) begin
         c = int'($urandom_range(0, 4));
         base = txn; b0 = bytes_seen;
         run($urandom, c, -1, 0, dc);
         chk("rnd_err", {31'd0, o_err}, 32'd0);
         chk("rnd_txns", txn - base, 7 + 8 * c);
         chk("rnd_bytes", bytes_seen - b0, c);
      end
      rnd = 1'b0;
      chk("final_req_q_empty", exp_req.size(), 0);
      chk("final_byte_q_empty", exp_byte.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
